apb_slave_ctrl: RTL and testbench

//  Parametrised APB slave front-end: terminates APB transfers and drives a simple register-backend strobe/ack interface.

---
 rtl/apb_slave_ctrl.sv | 172 +++++++++++++++++
 tb/tb_apb_slave_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_ctrl
// Brief    : APB slave front-end. It drives a strobe/ack register backend and
//            supports backend wait states, an ack timeout and decode-error
//            reporting on pslverr. Define APB_PSTRB_EN to enable byte strobes.
// Revision : 1.0  initial release
// ============================================================================
module apb_slave_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_REGS  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W/8-1:0] reg_wstrb,
    output logic                reg_wr,
    output logic                reg_rd,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic                reg_ack
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_TO     = c_CNT_W'(TIMEOUT);
    localparam logic [63:0]        c_ADDR_LIMIT = 64'(4 * N_REGS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write;
    logic                r_err;
    logic                r_skip;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pready;
    logic                r_pslverr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic                r_wr;
    logic                r_rd;

    logic                w_setup;
    logic                w_dec_err;
    logic [c_STRB_W-1:0] w_strb_in;
    logic                w_no_strb;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;

`ifdef APB_PSTRB_EN
    assign w_strb_in = pstrb;
    assign w_no_strb = pwrite && (pstrb == '0);
`else
    assign w_strb_in = '1;
    assign w_no_strb = 1'b0;
`endif

    assign w_setup   = psel && !penable;
    assign w_dec_err = (paddr[1:0] != 2'b00) || (64'(paddr) >= c_ADDR_LIMIT);
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc >= c_CNT_TO);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_skip    <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            r_rd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_setup) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_wstrb <= w_strb_in;
                        r_write <= pwrite;
                        r_err   <= w_dec_err;
                        // Transfers that must not reach the backend finish straight from REQ.
                        r_skip  <= w_dec_err || w_no_strb;
                        r_wr    <= pwrite && !w_dec_err && !w_no_strb;
                        r_rd    <= !pwrite && !w_dec_err;
                        r_cnt   <= '0;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ, c_ST_WAIT: begin
                    if (!psel) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else if (r_skip) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                        if (r_err && !r_write) begin
                            r_prdata <= '0;
                        end
                        r_state <= c_ST_DONE;
                    end else if (reg_ack) begin
                        // Ack is tested before the timeout so a last-cycle ack still succeeds.
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b0;
                        if (!r_write) begin
                            r_prdata <= reg_rdata;
                        end
                        r_state <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_cnt     <= w_cnt_inc;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        if (!r_write) begin
                            r_prdata <= '0;
                        end
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_DONE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign prdata    = r_prdata;
    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wstrb = r_wstrb;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_ctrl
// Brief    : Self-checking bench for apb_slave_ctrl using a transfer-level
//            timeline model and randomized APB/backend traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_slave_ctrl;

    localparam int c_NR = 16;
    localparam int c_TO = 15;
`ifdef APB_PSTRB_EN
    localparam bit c_PSTRB = 1'b1;
`else
    localparam bit c_PSTRB = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite, reg_ack;
    logic [31:0] paddr, pwdata, reg_rdata;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    logic [31:0] prdata, reg_addr, reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        pready, pslverr, reg_wr, reg_rd;

    always #5 pclk = ~pclk;

    apb_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .N_REGS(c_NR), .TIMEOUT(c_TO)) u_dut (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
`ifdef APB_PSTRB_EN
        .pstrb     (pstrb),
`endif
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    // Model state and per-cycle expectations
    logic [31:0] m_prdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        e_pready, e_pslverr, e_wr, e_rd;
    logic [31:0] e_prdata, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    bit          chk_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Observations for hand-computed literal checks
    logic [31:0] obs_prdata;
    logic        obs_err;
    int          obs_waits = 0, cur_waits = 0;
    int          n_pready = 0, n_wr = 0, n_rd = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            check("pready",    32'(pready),    32'(e_pready));
            check("reg_wr",    32'(reg_wr),    32'(e_wr));
            check("reg_rd",    32'(reg_rd),    32'(e_rd));
            check("prdata",    prdata,         e_prdata);
            check("reg_addr",  reg_addr,       e_addr);
            check("reg_wdata", reg_wdata,      e_wdata);
            check("reg_wstrb", 32'(reg_wstrb), 32'(e_wstrb));
            if (e_pready) check("pslverr", 32'(pslverr), 32'(e_pslverr));
        end
        if (pready === 1'b1) begin
            obs_prdata = prdata;
            obs_err    = pslverr;
            obs_waits  = cur_waits;
            n_pready++;
        end
        if (psel && !penable) cur_waits = 0;
        else if (psel && penable && pready !== 1'b1) cur_waits++;
        if (reg_wr === 1'b1) n_wr++;
        if (reg_rd === 1'b1) n_rd++;
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_exp();
        e_pready  = 1'b0;
        e_pslverr = 1'b0;
        e_wr      = 1'b0;
        e_rd      = 1'b0;
        e_prdata  = m_prdata;
        e_addr    = m_addr;
        e_wdata   = m_wdata;
        e_wstrb   = m_wstrb;
    endtask

    task automatic idle(input int n, input bit force_ack);
        for (int i = 0; i < n; i++) begin
            cyc();
            preset    = 1'b0;
            psel      = 1'b0;
            penable   = 1'b0;
            paddr     = $urandom;
            pwrite    = 1'($urandom % 2);
            reg_ack   = force_ack ? 1'b1 : 1'($urandom % 2);
            reg_rdata = $urandom;
            set_exp();
        end
    endtask

    // One APB transfer. ack_d: access cycle (0 = REQ) the backend acks, -1 = never.
    // abort_at / rst_at: access cycle in which psel drops / reset is applied, -1 = none.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int ack_d, input logic [31:0] rdata,
                        input int abort_at, input bit poke, input int rst_at);
        bit err, go, fin_err;
        int c, ab, rs;
        cyc();
        preset  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
`ifdef APB_PSTRB_EN
        pstrb   = strb;
`endif
        reg_ack   = 1'($urandom % 2);
        reg_rdata = $urandom;
        set_exp();
        err = (addr[1:0] != 2'b00) || (addr >= 32'(4 * c_NR));
        go  = !err && !(c_PSTRB && wr && strb == 4'b0000);
        if (!go) begin
            c = 2; fin_err = err;
        end else if (ack_d >= 0 && ack_d < c_TO) begin
            c = 2 + ack_d; fin_err = 1'b0;
        end else begin
            c = 1 + c_TO; fin_err = 1'b1;
        end
        ab = (abort_at >= 1 && abort_at < c) ? abort_at : -1;
        rs = (rst_at >= 1 && rst_at < c) ? rst_at : -1;
        for (int k = 1; k <= c; k++) begin
            cyc();
            if (k == 1) begin
                m_addr  = addr;
                m_wdata = wdata;
                m_wstrb = c_PSTRB ? strb : 4'hF;
            end
            set_exp();
            psel      = (k == ab) ? 1'b0 : 1'b1;
            penable   = (k == ab) ? 1'b0 : 1'b1;
            preset    = (k == rs);
            reg_ack   = go && (ack_d >= 0) && (k == ack_d + 1);
            reg_rdata = reg_ack ? rdata : $urandom;
            if (k == 1) begin
                e_wr = wr && go;
                e_rd = !wr && go;
            end
            if (k == c) begin
                e_pready  = 1'b1;
                e_pslverr = fin_err;
                if (!wr) begin
                    m_prdata = fin_err ? 32'h0 : rdata;
                    e_prdata = m_prdata;
                end
                if (poke) begin
                    psel    = 1'b1;
                    penable = 1'b0;
                    paddr   = $urandom;
                end
            end
            if (k == ab) return;
            if (k == rs) begin
                m_prdata = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
                return;
            end
        end
        if (poke) idle(1, 1'b0);
    endtask

    initial begin
        int w0, r0, p0, sel, ack_d, ab;
        logic [31:0] addr;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; reg_ack = 1'b0; reg_rdata = '0;
`ifdef APB_PSTRB_EN
        pstrb = '0;
`endif
        m_prdata = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        set_exp();
        @(posedge pclk);
        #1;
        chk_en = 1'b1;
        check("rst_pready",  32'(pready), 32'h0);
        check("rst_reg_rd",  32'(reg_rd), 32'h0);
        check("rst_prdata",  prdata,      32'h0);
        check("rst_wstrb",   32'(reg_wstrb), 32'h0);
        cyc();
        preset = 1'b0;
        set_exp();

        // Write 0x8, ack in REQ
        w0 = n_wr;
        xfer(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 32'h0, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_wr_pulses", 32'(n_wr - w0), 32'd1);
        check("lit_wr_err",    32'(obs_err),   32'd0);
        check("lit_wr_waits",  32'(obs_waits), 32'd1);
        check("lit_wdata",     reg_wdata,      32'hDEADBEEF);

        // Read 0x4, 5 wait states
        xfer(1'b0, 32'h4, 32'h0, 4'hF, 4, 32'h12345678, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_rd4_data",  obs_prdata,     32'h12345678);
        check("lit_rd4_waits", 32'(obs_waits), 32'd5);

        // Decode errors: out of range and misaligned
        r0 = n_rd;
        xfer(1'b0, 32'h40, 32'h0, 4'hF, 0, 32'h11111111, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_rng_err",  32'(obs_err), 32'd1);
        check("lit_rng_data", obs_prdata,   32'h0);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 1, 32'hA5A5A5A5, -1, 1'b0, -1);
        xfer(1'b0, 32'h6, 32'h0, 4'hF, 0, 32'h22222222, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_mis_err",  32'(obs_err),    32'd1);
        check("lit_mis_data", obs_prdata,      32'h0);
        check("lit_err_rd",   32'(n_rd - r0),  32'd1);

        // Timeout, then late acks ignored; then ack coinciding with the timeout
        p0 = n_pready;
        xfer(1'b0, 32'hC, 32'h0, 4'hF, -1, 32'h0, -1, 1'b0, -1);
        idle(3, 1'b1);
        check("lit_to_err",    32'(obs_err),       32'd1);
        check("lit_to_waits",  32'(obs_waits),     32'd15);
        check("lit_to_pready", 32'(n_pready - p0), 32'd1);
        xfer(1'b1, 32'h10, 32'h55AA55AA, 4'hF, 14, 32'h0, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_ackto_err",   32'(obs_err),   32'd0);
        check("lit_ackto_waits", 32'(obs_waits), 32'd15);

        // Master abort in WAIT, ack afterwards, then a normal read
        p0 = n_pready;
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 3, 32'h77777777, 2, 1'b0, -1);
        idle(2, 1'b1);
        check("lit_abort_pready", 32'(n_pready - p0), 32'd0);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 0, 32'h0BADF00D, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_after_abort", obs_prdata, 32'h0BADF00D);

        // Setup presented during DONE must not be accepted
        xfer(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 32'h0, -1, 1'b1, -1);
        idle(1, 1'b0);

        // Reset mid-transfer
        p0 = n_pready;
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 5, 32'h33333333, -1, 1'b0, 2);
        idle(2, 1'b0);
        check("lit_rst_pready", 32'(n_pready - p0), 32'd0);
        check("lit_rst_addr",   reg_addr,           32'h0);

`ifdef APB_PSTRB_EN
        xfer(1'b1, 32'h8, 32'h01020304, 4'b0011, 0, 32'h0, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_strb", 32'(reg_wstrb), 32'h3);
        w0 = n_wr; p0 = n_pready;
        xfer(1'b1, 32'h8, 32'h05060708, 4'b0000, 0, 32'h0, -1, 1'b0, -1);
        idle(1, 1'b0);
        check("lit_zstrb_wr",     32'(n_wr - w0),     32'd0);
        check("lit_zstrb_pready", 32'(n_pready - p0), 32'd1);
        check("lit_zstrb_err",    32'(obs_err),       32'd0);
`endif

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            sel  = int'($urandom_range(9, 0));
            addr = 32'($urandom_range(15, 0)) << 2;
            if (sel == 0) addr = addr | 32'($urandom_range(3, 1));
            else if (sel == 1) addr = 32'h40 + ($urandom % 32'h100);
            sel   = int'($urandom_range(9, 0));
            ack_d = int'($urandom_range(5, 0));
            if (sel == 0) ack_d = -1;
            else if (sel == 1) ack_d = int'($urandom_range(16, 13));
            ab = ($urandom % 10 == 0) ? int'($urandom_range(3, 1)) : -1;
            xfer(1'($urandom % 2), addr, $urandom,
                 ($urandom % 6 == 0) ? 4'h0 : 4'($urandom),
                 ack_d, $urandom, ab, ($urandom % 8 == 0), -1);
            idle(int'($urandom_range(2, 0)), 1'b0);
        end

        idle(2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
